// File: rtl/demux_pkg.sv
// Shared definitions for the demux scan driver.
//   NUM_CH       - number of demux output channels
//   SEL_W        - width of the channel select
//   CNT_W        - width of the dwell counter (covers DWELL_CYCLES up to 255)
//   scan_state_t - scan FSM state encoding
package demux_pkg;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [0:0] {
        IDLE,
        SCAN
    } scan_state_t;

endpackage

// File: rtl/demux_next_channel.sv
// Combinational priority finder for the next enabled channel.
//   mask      in  NUM_CH : channel-enable mask
//   cur       in  SEL_W  : current channel
//   from_none in  1      : 1 = ignore cur and return the lowest set bit
//   next_ch   out SEL_W  : lowest set index strictly above cur (or lowest overall)
//   found     out 1      : a qualifying set bit exists
module demux_next_channel
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_none,
    output logic [SEL_W-1:0]  next_ch,
    output logic              found
);

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_none || (i > int'(cur)))) begin
                next_ch = SEL_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_scan_driver.sv
// Sequencer for the 1-to-16 demux: accepts a data word and channel mask, then
// walks the enabled channels in ascending order, holding each for DWELL_CYCLES.
//   clk          in  1  : clock
//   rst          in  1  : synchronous active-high reset
//   in_valid     in  1  : upstream word available
//   in_ready     out 1  : word can be accepted this cycle
//   in_data      in  16 : bit k goes to demux output k
//   in_mask      in  16 : bit k enables channel k
//   sel          out 4  : demux channel select
//   din          out 1  : demux data bit
//   active       out 1  : sel/din valid this cycle
//   frame_start  out 1  : first active cycle of a frame
//   frame_done   out 1  : cycle after the last active cycle
module demux_scan_driver
    import demux_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1  // legal range 1..255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] in_data,
    input  logic [NUM_CH-1:0] in_mask,
    output logic [SEL_W-1:0]  sel,
    output logic              din,
    output logic              active,
    output logic              frame_start,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_t       state_q, state_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              din_q, din_d;
    logic              active_q, active_d;
    logic              start_q, start_d;
    logic              done_q, done_d;

    logic [SEL_W-1:0]  first_ch;
    logic              first_found;
    logic [SEL_W-1:0]  next_ch;
    logic              next_found;

    // First channel is searched on the incoming mask so SCAN starts right after accept.
    demux_next_channel u_first (
        .mask      (in_mask),
        .cur       ('0),
        .from_none (1'b1),
        .next_ch   (first_ch),
        .found     (first_found)
    );

    demux_next_channel u_next (
        .mask      (mask_q),
        .cur       (ch_q),
        .from_none (1'b0),
        .next_ch   (next_ch),
        .found     (next_found)
    );

    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        sel_d    = '0;
        din_d    = 1'b0;
        active_d = 1'b0;
        start_d  = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d = in_data;
                    mask_d = in_mask;
                    if (first_found) begin
                        state_d  = SCAN;
                        ch_d     = first_ch;
                        cnt_d    = '0;
                        sel_d    = first_ch;
                        din_d    = in_data[first_ch];
                        active_d = 1'b1;
                        start_d  = 1'b1;
                    end else begin
                        // Empty frame: report completion without any active cycle.
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    if (next_found) begin
                        ch_d     = next_ch;
                        cnt_d    = '0;
                        sel_d    = next_ch;
                        din_d    = data_q[next_ch];
                        active_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    sel_d    = ch_q;
                    din_d    = data_q[ch_q];
                    active_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            din_q    <= 1'b0;
            active_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            din_q    <= din_d;
            active_q <= active_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign sel         = sel_q;
    assign din         = din_q;
    assign active      = active_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_demux_scan_driver.sv
// Directed self-checking bench for demux_scan_driver: one instance with the
// default dwell of 1 and one with a dwell of 3.
module tb_demux_scan_driver;

    logic        clk = 1'b0;
    logic        rst;

    logic        v1, rdy1, din1, act1, fs1, fd1;
    logic [15:0] data1, mask1;
    logic [3:0]  sel1;

    logic        v3, rdy3, din3, act3, fs3, fd3;
    logic [15:0] data3, mask3;
    logic [3:0]  sel3;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] full_din;
    int          sparse_sel [9];

    always #5 clk = ~clk;

    demux_scan_driver #(.DWELL_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (v1),
        .in_ready    (rdy1),
        .in_data     (data1),
        .in_mask     (mask1),
        .sel         (sel1),
        .din         (din1),
        .active      (act1),
        .frame_start (fs1),
        .frame_done  (fd1)
    );

    demux_scan_driver #(.DWELL_CYCLES(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (v3),
        .in_ready    (rdy3),
        .in_data     (data3),
        .in_mask     (mask3),
        .sel         (sel3),
        .din         (din3),
        .active      (act3),
        .frame_start (fs3),
        .frame_done  (fd3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet1(input string tag);
        check({tag, " sel"}, 32'(sel1), 0);
        check({tag, " din"}, 32'(din1), 0);
        check({tag, " active"}, 32'(act1), 0);
        check({tag, " start"}, 32'(fs1), 0);
    endtask

    initial begin
        full_din   = 16'hA5C3;
        sparse_sel = '{0, 0, 0, 5, 5, 5, 15, 15, 15};

        rst = 1'b1;
        v1 = 1'b0; data1 = '0; mask1 = '0;
        v3 = 1'b0; data3 = '0; mask3 = '0;

        // Reset state
        tick();
        tick();
        check("rst in_ready", 32'(rdy1), 0);
        check_quiet1("rst");
        check("rst done", 32'(fd1), 0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(rdy1), 1);
        check("post-rst in_ready d3", 32'(rdy3), 1);

        // Full mask, D=1
        v1 = 1'b1; data1 = 16'hA5C3; mask1 = 16'hFFFF;
        tick();
        v1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("full sel[%0d]", k), 32'(sel1), 32'(k));
            check($sformatf("full din[%0d]", k), 32'(din1), 32'(full_din[k]));
            check($sformatf("full active[%0d]", k), 32'(act1), 1);
            check($sformatf("full start[%0d]", k), 32'(fs1), (k == 0) ? 1 : 0);
            check($sformatf("full done[%0d]", k), 32'(fd1), 0);
            check($sformatf("full ready[%0d]", k), 32'(rdy1), 0);
            tick();
        end
        check("full done", 32'(fd1), 1);
        check("full ready at done", 32'(rdy1), 1);
        check_quiet1("full end");
        tick();
        check("full done pulse", 32'(fd1), 0);

        // Sparse mask, D=3
        v3 = 1'b1; data3 = 16'hFFFF; mask3 = 16'h8021;
        tick();
        v3 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("sparse sel[%0d]", k), 32'(sel3), 32'(sparse_sel[k]));
            check($sformatf("sparse din[%0d]", k), 32'(din3), 1);
            check($sformatf("sparse active[%0d]", k), 32'(act3), 1);
            check($sformatf("sparse start[%0d]", k), 32'(fs3), (k == 0) ? 1 : 0);
            check($sformatf("sparse done[%0d]", k), 32'(fd3), 0);
            tick();
        end
        check("sparse done", 32'(fd3), 1);
        check("sparse active end", 32'(act3), 0);
        check("sparse sel end", 32'(sel3), 0);
        tick();
        check("sparse done pulse", 32'(fd3), 0);

        // Zero mask
        v1 = 1'b1; data1 = 16'hFFFF; mask1 = 16'h0000;
        tick();
        v1 = 1'b0;
        check("zero done", 32'(fd1), 1);
        check_quiet1("zero");
        check("zero ready", 32'(rdy1), 1);
        tick();
        check("zero done pulse", 32'(fd1), 0);
        check("zero active", 32'(act1), 0);

        // Back-to-back: word A (ch1=1, ch2=0), then word B (ch3=1, ch4=0)
        v1 = 1'b1; data1 = 16'h0002; mask1 = 16'h0006;
        tick();
        data1 = 16'h000C; mask1 = 16'h0018;  // word B presented while A scans
        check("b2b A sel1", 32'(sel1), 1);
        check("b2b A din1", 32'(din1), 1);
        check("b2b A start", 32'(fs1), 1);
        tick();
        check("b2b A sel2", 32'(sel1), 2);
        check("b2b A din2 latched", 32'(din1), 0);
        check("b2b A start2", 32'(fs1), 0);
        tick();
        check("b2b A done", 32'(fd1), 1);
        check("b2b ready at done", 32'(rdy1), 1);
        check("b2b gap active", 32'(act1), 0);
        tick();
        v1 = 1'b0;
        check("b2b B start", 32'(fs1), 1);
        check("b2b B sel3", 32'(sel1), 3);
        check("b2b B din3", 32'(din1), 1);
        tick();
        check("b2b B sel4", 32'(sel1), 4);
        check("b2b B din4", 32'(din1), 0);
        tick();
        check("b2b B done", 32'(fd1), 1);
        tick();

        // Reset mid-scan of a full-mask frame
        v1 = 1'b1; data1 = 16'hA5C3; mask1 = 16'hFFFF;
        tick();
        v1 = 1'b0;
        tick();
        tick();
        tick();
        check("mid sel T+4", 32'(sel1), 3);
        rst = 1'b1;
        #1;
        check("mid ready in rst", 32'(rdy1), 0);
        tick();
        check_quiet1("mid rst");
        check("mid rst done", 32'(fd1), 0);
        check("mid ready in rst2", 32'(rdy1), 0);
        rst = 1'b0;
        #1;
        check("mid ready release", 32'(rdy1), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid no done[%0d]", k), 32'(fd1), 0);
            check($sformatf("mid no active[%0d]", k), 32'(act1), 0);
        end

        // New frame after reset
        v1 = 1'b1; data1 = 16'h0400; mask1 = 16'h0400;
        tick();
        v1 = 1'b0;
        check("post start", 32'(fs1), 1);
        check("post sel", 32'(sel1), 10);
        check("post din", 32'(din1), 1);
        tick();
        check("post done", 32'(fd1), 1);
        check("post ready", 32'(rdy1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/demux_scan_driver.md
# demux_scan_driver

Upstream sequencer for the 1-to-16 demultiplexer stage. Accepts one 16-bit parallel word plus a 16-bit channel-enable mask over a valid/ready handshake. Scans the enabled channels in ascending order, driving the demux `sel`/`din` pair, and holds each channel for a programmable dwell. Delivers each bit of the word to its own demux output line, with frame start/done markers for the consumer.

## Interface
- `DWELL_CYCLES`, default 1: cycles each enabled channel is held on `sel`/`din`; legal range 1..255.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: upstream word available.
- `in_ready`  out  1: block can accept a word this cycle.
- `in_data`  in  16: bit k is the value destined for demux output k.
- `in_mask`  in  16: bit k = 1 means channel k is scanned; 0 means it is skipped.
- `sel`  out  4: channel select to demux.
- `din`  out  1: data bit to demux.
- `active`  out  1: `sel`/`din` carry a valid channel this cycle.
- `frame_start`  out  1: one-cycle pulse on the first active cycle of a frame.
- `frame_done`  out  1: one-cycle pulse on the cycle after the last active cycle.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SCAN: `in_ready`=0.
- Accept: when `in_valid && in_ready` at an edge, latch `in_data`/`in_mask` into internal registers.
- Nonzero mask: go to SCAN with channel register = lowest set mask bit and dwell counter = 0.
- Zero mask: stay in IDLE and pulse `frame_done` next cycle, with no `frame_start` and no `active`.
- SCAN outputs: `sel`=current channel, `din`=latched data[channel], `active`=1.
- Dwell counter increments each cycle. When it reaches `DWELL_CYCLES`-1:
  - If a higher-index mask bit is set, move to that channel and clear the counter.
  - Otherwise go to IDLE and assert `frame_done`.
- Outside SCAN: `sel`=0, `din`=0, `active`=0. The downstream demux then drives all outputs low.
- `in_data`/`in_mask` changes while in SCAN have no effect; only latched values are used.
- Back-to-back frames: `frame_done` is asserted in IDLE with `in_ready`=1, so a word may be accepted on the same cycle `frame_done` is high.
- Reset:
  - State = IDLE; `sel`=0, `din`=0, `active`=0, `frame_start`=0, `frame_done`=0.
  - `in_ready` is forced to 0 while `rst`=1.
  - Latched data/mask cleared.
  - Reset mid-scan aborts the frame with no `frame_done`.

## Timing
- All outputs registered except `in_ready`, which is decoded from state and gated by `rst`.
- Accept at edge T: `frame_start`=1, `active`=1, `sel`=first channel on cycle T+1.
- Let N = popcount(mask) and D = `DWELL_CYCLES`:
  - Active cycles run T+1 .. T+N*D, contiguous with no gaps between channels.
  - `frame_done` is asserted in cycle T+N*D+1.
- Zero mask: `frame_done` in cycle T+1.
- Skipped channels consume zero cycles; the next-channel search is single-cycle, not iterative.
- Channel 15 as the last enabled channel: no wrap to 0; the frame ends.
- Minimum frame period with back-to-back input: N*D+1 cycles.

## Structure
- Shared package `demux_pkg`:
  - `NUM_CH`=16 and `SEL_W`=4.
  - `scan_state_t` enum {IDLE, SCAN}.
  - Dwell counter width constant of 8 bits.
- Sub-module `demux_next_channel`: combinational priority finder.
  - Inputs: mask[15:0] and current channel.
  - Outputs: lowest set index strictly above current, plus a `found` flag.
  - A variant with current = "none" returns the lowest set bit, used at accept.
- Top: FSM, data/mask registers, dwell counter and output registers.

## Test plan
- Full mask, D=1: data=16'hA5C3, mask=16'hFFFF.
  - `sel` steps 0..15 on cycles T+1..T+16.
  - `din` follows 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `frame_start` at T+1, `frame_done` at T+17.
- Sparse mask, D=3: mask=16'h8021, data=16'hFFFF.
  - `sel`=0 for 3 cycles, then 5 for 3 cycles, then 15 for 3 cycles, all with `din`=1.
  - `frame_done` at T+10.
- Zero mask: mask=0.
  - `frame_done` at T+1.
  - `active`, `frame_start` and `sel` stay 0; `in_ready` remains 1.
- Back-to-back:
  - Hold `in_valid`=1 with two words; the second is accepted on the first word's `frame_done` cycle.
  - Second `frame_start` follows on the next cycle.
  - `in_data` changes during SCAN do not alter `din`.
- Reset mid-scan: assert `rst` at cycle T+4 of a full-mask frame.
  - Next cycle: all outputs 0, no `frame_done`.
  - `in_ready`=0 while `rst`=1, then 1 after release.
  - A new frame runs normally afterwards.
